// File: rtl/cpack_pkg.sv
// Shared C-Pack definitions: code enums, decoded pattern type and helpers
// used by the compressor, the bitstream parser and the word decoder.
package cpack_pkg;

  typedef enum logic [1:0] {
    ZERO  = 2'b00,
    RAW   = 2'b01,
    MATCH = 2'b10,
    EXT   = 2'b11
  } code_e;

  typedef enum logic [1:0] {
    MMXX = 2'b00,
    ZZZX = 2'b01,
    MMMX = 2'b10,
    RSVD = 2'b11
  } code_bak_e;

  typedef enum logic [2:0] {
    PAT_ZZZZ,
    PAT_XXXX,
    PAT_MMMM,
    PAT_MMXX,
    PAT_ZZZX,
    PAT_MMMX,
    PAT_RSVD
  } pattern_e;

  // Map the primary/secondary code pair onto a single pattern.
  function automatic pattern_e classify(input logic [1:0] codes, input logic [1:0] codes_bak);
    pattern_e pat;
    case (code_e'(codes))
      ZERO:    pat = PAT_ZZZZ;
      RAW:     pat = PAT_XXXX;
      MATCH:   pat = PAT_MMMM;
      default: begin
        case (code_bak_e'(codes_bak))
          MMXX:    pat = PAT_MMXX;
          ZZZX:    pat = PAT_ZZZX;
          MMMX:    pat = PAT_MMMX;
          default: pat = PAT_RSVD;
        endcase
      end
    endcase
    return pat;
  endfunction

  // Patterns that carry new information into the dictionary.
  function automatic logic pattern_pushes(input pattern_e pat);
    return (pat == PAT_XXXX) || (pat == PAT_MMXX) || (pat == PAT_MMMX);
  endfunction

endpackage

// File: rtl/cpack_dict.sv
// FIFO-replacement dictionary for C-Pack: register file with a
// combinational read port, one write port at wr_ptr, and a full clear.
module cpack_dict #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic [$clog2(DEPTH)-1:0] rd_idx,
  output logic [WIDTH-1:0]         rd_data
);

  localparam int IDX_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [IDX_W-1:0] wr_ptr;

  // Clear wins over a write in the same cycle; the pointer wraps naturally
  // because DEPTH is a power of two, overwriting the oldest entry.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
    end else if (wr_en) begin
      mem[wr_ptr] <= wr_data;
      wr_ptr      <= wr_ptr + 1'b1;
    end
  end

  // Read is combinational so a push is visible to the very next input.
  always_comb begin
    rd_data = mem[rd_idx];
  end

endmodule

// File: rtl/cpack_word_decoder.sv
// Streaming C-Pack word decompressor: one code group in, one word out,
// one cycle of latency, dictionary updated in lockstep with the compressor.
// Optional statistics counters are enabled by defining CPACK_DEC_STATS_EN.
module cpack_word_decoder
  import cpack_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int DICT_DEPTH = 16,
  parameter int LOW_BITS   = 8,
  parameter int STAT_W     = 16
) (
  input  logic                          i_clk,
  input  logic                          i_reset,
  input  logic                          i_clear,
  input  logic                          i_valid,
  output logic                          o_ready,
  input  logic [1:0]                    i_codes,
  input  logic [1:0]                    i_codes_bak,
  input  logic [WIDTH-1:0]              i_payload,
  input  logic [$clog2(DICT_DEPTH)-1:0] i_idx,
  output logic                          o_valid,
  input  logic                          i_ready,
  output logic [WIDTH-1:0]              o_word,
  output logic                          o_err
`ifdef CPACK_DEC_STATS_EN
  ,
  output logic [STAT_W-1:0]             o_cnt_zero,
  output logic [STAT_W-1:0]             o_cnt_match,
  output logic [STAT_W-1:0]             o_cnt_partial,
  output logic [STAT_W-1:0]             o_cnt_raw
`endif
);

  localparam int HALF = WIDTH / 2;

  if ((WIDTH % 2) != 0 || WIDTH < 16 || DICT_DEPTH < 2 ||
      (DICT_DEPTH & (DICT_DEPTH - 1)) != 0 || LOW_BITS < 1 ||
      LOW_BITS >= HALF || STAT_W < 2) begin : g_param_check
    $error("cpack_word_decoder: illegal parameter combination");
  end

  pattern_e         pattern;
  logic             accept;
  logic             push;
  logic [WIDTH-1:0] dict_rd;
  logic [WIDTH-1:0] dec_word;

  // Handshake: a held output blocks new input; no path from i_valid.
  always_comb begin
    o_ready = !o_valid || i_ready;
    accept  = i_valid && o_ready;
    pattern = classify(i_codes, i_codes_bak);
    push    = accept && pattern_pushes(pattern) && !i_clear;
  end

  cpack_dict #(
    .WIDTH (WIDTH),
    .DEPTH (DICT_DEPTH)
  ) u_dict (
    .clk     (i_clk),
    .reset   (i_reset),
    .clear   (i_clear),
    .wr_en   (push),
    .wr_data (dec_word),
    .rd_idx  (i_idx),
    .rd_data (dict_rd)
  );

  // Reconstruct the word from the dictionary entry and literal bits.
  always_comb begin
    dec_word = i_payload;
    case (pattern)
      PAT_ZZZZ: dec_word = '0;
      PAT_XXXX: dec_word = i_payload;
      PAT_MMMM: dec_word = dict_rd;
      PAT_MMXX: dec_word = {dict_rd[WIDTH-1:HALF], i_payload[HALF-1:0]};
      PAT_ZZZX: dec_word = {{(WIDTH-LOW_BITS){1'b0}}, i_payload[LOW_BITS-1:0]};
      PAT_MMMX: dec_word = {dict_rd[WIDTH-1:LOW_BITS], i_payload[LOW_BITS-1:0]};
      default:  dec_word = i_payload;
    endcase
  end

  // Output register: load on accept, drop valid once consumed, hold on stall.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_valid <= 1'b0;
      o_word  <= '0;
    end else if (accept) begin
      o_valid <= 1'b1;
      o_word  <= dec_word;
    end else if (i_ready) begin
      o_valid <= 1'b0;
    end
  end

  // Sticky reserved-code flag; only reset clears it.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_err <= 1'b0;
    end else if (accept && pattern == PAT_RSVD) begin
      o_err <= 1'b1;
    end
  end

`ifdef CPACK_DEC_STATS_EN
  localparam logic [STAT_W-1:0] STAT_ONE = {{(STAT_W-1){1'b0}}, 1'b1};
  localparam logic [STAT_W-1:0] STAT_MAX = {STAT_W{1'b1}};

  // Saturating per-class counters; i_clear deliberately leaves them alone.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_cnt_zero    <= '0;
      o_cnt_match   <= '0;
      o_cnt_partial <= '0;
      o_cnt_raw     <= '0;
    end else if (accept) begin
      case (pattern)
        PAT_ZZZZ, PAT_ZZZX:
          if (o_cnt_zero != STAT_MAX) o_cnt_zero <= o_cnt_zero + STAT_ONE;
        PAT_MMMM:
          if (o_cnt_match != STAT_MAX) o_cnt_match <= o_cnt_match + STAT_ONE;
        PAT_MMXX, PAT_MMMX:
          if (o_cnt_partial != STAT_MAX) o_cnt_partial <= o_cnt_partial + STAT_ONE;
        default:
          if (o_cnt_raw != STAT_MAX) o_cnt_raw <= o_cnt_raw + STAT_ONE;
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_cpack_word_decoder.sv
// Testbench for cpack_word_decoder: directed sequence followed by random
// traffic, all checked against a word-level reference model.
module tb_cpack_word_decoder;

  localparam int W  = 32;
  localparam int DD = 16;
  localparam int LB = 8;
  localparam int SW = 2;

  logic        i_clk = 1'b0;
  logic        i_reset, i_clear, i_valid, i_ready;
  logic        o_ready, o_valid, o_err;
  logic [1:0]  i_codes, i_codes_bak;
  logic [31:0] i_payload;
  logic [3:0]  i_idx;
  logic [31:0] o_word;
`ifdef CPACK_DEC_STATS_EN
  logic [SW-1:0] o_cnt_zero, o_cnt_match, o_cnt_partial, o_cnt_raw;
`endif

  always #5 i_clk = ~i_clk;

  cpack_word_decoder #(
    .WIDTH(W), .DICT_DEPTH(DD), .LOW_BITS(LB), .STAT_W(SW)
  ) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_clear(i_clear), .i_valid(i_valid),
    .o_ready(o_ready), .i_codes(i_codes), .i_codes_bak(i_codes_bak),
    .i_payload(i_payload), .i_idx(i_idx), .o_valid(o_valid), .i_ready(i_ready),
    .o_word(o_word), .o_err(o_err)
`ifdef CPACK_DEC_STATS_EN
    , .o_cnt_zero(o_cnt_zero), .o_cnt_match(o_cnt_match),
    .o_cnt_partial(o_cnt_partial), .o_cnt_raw(o_cnt_raw)
`endif
  );

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [31:0] m_dict [DD];
  int          m_wp;
  bit          m_valid;
  logic [31:0] m_word;
  bit          m_err;
  int          m_cnt [4];   // 0 zero, 1 match, 2 partial, 3 raw

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Word-level meaning of each code pair, written with masks and arithmetic.
  function automatic logic [31:0] ref_decode(input logic [1:0] c, input logic [1:0] b,
                                             input logic [31:0] p, input logic [31:0] d,
                                             output bit push, output int cls, output bit rsvd);
    logic [31:0] w;
    push = 0; rsvd = 0;
    if (c == 2'd0) begin w = 0; cls = 0; end
    else if (c == 2'd1) begin w = p; push = 1; cls = 3; end
    else if (c == 2'd2) begin w = d; cls = 1; end
    else if (b == 2'd0) begin w = (d & 32'hFFFF_0000) | (p & 32'h0000_FFFF); push = 1; cls = 2; end
    else if (b == 2'd1) begin w = p % 256; cls = 0; end
    else if (b == 2'd2) begin w = (d & ~32'hFF) | (p & 32'hFF); push = 1; cls = 2; end
    else begin w = p; rsvd = 1; cls = 3; end
    return w;
  endfunction

  task automatic chk_stats();
`ifdef CPACK_DEC_STATS_EN
    chk("cnt_zero",    32'(o_cnt_zero),    32'(m_cnt[0]));
    chk("cnt_match",   32'(o_cnt_match),   32'(m_cnt[1]));
    chk("cnt_partial", 32'(o_cnt_partial), 32'(m_cnt[2]));
    chk("cnt_raw",     32'(o_cnt_raw),     32'(m_cnt[3]));
`endif
  endtask

  // One clock cycle of stimulus with full model update and output checks.
  task automatic cycle(input bit v, input logic [1:0] c, input logic [1:0] b,
                       input logic [31:0] p, input logic [3:0] idx,
                       input bit clr, input bit rdy);
    bit exp_rdy, acc, push, rsvd;
    int cls;
    logic [31:0] w;
    i_valid = v; i_codes = c; i_codes_bak = b; i_payload = p;
    i_idx = idx; i_clear = clr; i_ready = rdy;
    #1;
    exp_rdy = !m_valid || rdy;
    chk("o_ready", 32'(o_ready), 32'(exp_rdy));
    acc = v && exp_rdy;
    w = ref_decode(c, b, p, m_dict[idx], push, cls, rsvd);
    @(posedge i_clk);
    #1;
    if (acc) begin
      m_valid = 1; m_word = w;
      if (rsvd) m_err = 1;
      if (m_cnt[cls] < (1 << SW) - 1) m_cnt[cls]++;
    end else if (rdy) begin
      m_valid = 0;
    end
    if (clr) begin
      for (int i = 0; i < DD; i++) m_dict[i] = 0;
      m_wp = 0;
    end else if (acc && push) begin
      m_dict[m_wp] = w;
      m_wp = (m_wp + 1) % DD;
    end
    chk("o_valid", 32'(o_valid), 32'(m_valid));
    if (m_valid) chk("o_word", o_word, m_word);
    chk("o_err", 32'(o_err), 32'(m_err));
    chk_stats();
  endtask

  task automatic put(input logic [1:0] c, input logic [1:0] b,
                     input logic [31:0] p, input logic [3:0] idx);
    cycle(1, c, b, p, idx, 0, 1);
  endtask

  task automatic do_reset();
    i_reset = 1; i_valid = 0; i_clear = 0; i_ready = 1;
    i_codes = 0; i_codes_bak = 0; i_payload = 0; i_idx = 0;
    repeat (2) @(posedge i_clk);
    #1;
    i_reset = 0;
    for (int i = 0; i < DD; i++) m_dict[i] = 0;
    m_wp = 0; m_valid = 0; m_word = 0; m_err = 0;
    for (int i = 0; i < 4; i++) m_cnt[i] = 0;
    chk("rst_valid", 32'(o_valid), 32'd0);
    chk("rst_word", o_word, 32'd0);
    chk("rst_err", 32'(o_err), 32'd0);
    chk_stats();
  endtask

  initial begin
    do_reset();

    // Raw word, then read it back from entry 0
    put(2'b01, 2'b00, 32'hDEADBEEF, 4'd0);
    chk("raw_deadbeef", o_word, 32'hDEADBEEF);
    put(2'b10, 2'b00, 32'h0, 4'd0);
    chk("dict0_deadbeef", o_word, 32'hDEADBEEF);

    // Back-to-back dependent words on a fresh dictionary
    cycle(0, 2'b00, 2'b00, 32'h0, 4'd0, 1, 1);
    put(2'b01, 2'b00, 32'h12345678, 4'd0);
    chk("b2b_raw", o_word, 32'h12345678);
    put(2'b11, 2'b00, 32'h0000ABCD, 4'd0);
    chk("b2b_mmxx", o_word, 32'h1234ABCD);
    put(2'b10, 2'b00, 32'h0, 4'd1);
    chk("b2b_mmmm", o_word, 32'h1234ABCD);

    // Wrap-around: 17 pushes overwrite entry 0
    cycle(0, 2'b00, 2'b00, 32'h0, 4'd0, 1, 1);
    for (int k = 1; k <= 17; k++) put(2'b01, 2'b00, 32'(k), 4'd0);
    put(2'b10, 2'b00, 32'h0, 4'd0);
    chk("wrap_idx0", o_word, 32'd17);
    put(2'b10, 2'b00, 32'h0, 4'd1);
    chk("wrap_idx1", o_word, 32'd2);

    // zzzx and mmmx
    put(2'b11, 2'b01, 32'hFFFF_FF3C, 4'd0);
    chk("zzzx", o_word, 32'h0000_003C);
    put(2'b11, 2'b10, 32'h0000_00EE, 4'd1);
    chk("mmmx", o_word, 32'h0000_00EE);

    // Stall for 3 cycles with a pending input
    put(2'b01, 2'b00, 32'h77, 4'd0);
    for (int k = 0; k < 3; k++) begin
      cycle(1, 2'b01, 2'b00, 32'h99, 4'd0, 0, 0);
      chk("stall_hold", o_word, 32'h77);
      chk("stall_ready", 32'(o_ready), 32'd0);
    end
    cycle(1, 2'b10, 2'b00, 32'h0, 4'd0, 0, 1);

    // Clear coincident with an accept: word emitted, push dropped
    cycle(1, 2'b01, 2'b00, 32'hAA, 4'd0, 1, 1);
    chk("clear_emit", o_word, 32'hAA);
    put(2'b10, 2'b00, 32'h0, 4'd0);
    chk("clear_dict0", o_word, 32'h0);

    // Reserved code: passthrough, sticky error, no push
    put(2'b11, 2'b11, 32'h55, 4'd0);
    chk("rsvd_word", o_word, 32'h55);
    chk("rsvd_err", 32'(o_err), 32'd1);
    put(2'b10, 2'b00, 32'h0, 4'd0);
    chk("rsvd_nopush", o_word, 32'h0);
    chk("rsvd_sticky", 32'(o_err), 32'd1);

    // Random traffic
    for (int k = 0; k < 400; k++) begin
      cycle($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
            $urandom, 4'($urandom_range(0, DD - 1)),
            $urandom_range(0, 19) == 0, $urandom_range(0, 3) != 0);
    end

    // Mid-stream reset drops the in-flight word
    put(2'b01, 2'b00, 32'h1234, 4'd0);
    do_reset();

    // Statistics saturation (checked through the model when enabled)
    for (int k = 0; k < 5; k++) put(2'b00, 2'b00, 32'h0, 4'd0);
`ifdef CPACK_DEC_STATS_EN
    chk("cnt_zero_sat", 32'(o_cnt_zero), 32'd3);
    chk("cnt_match_0", 32'(o_cnt_match), 32'd0);
`endif
    chk("zero_word", o_word, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
